// File: rtl/gcd_controller.sv
// rtl/gcd_controller.sv - sequencing FSM for the 8-bit subtract-and-compare GCD datapath
//
// Loads operands on start, steers A-B / B-A write-backs from the comparator flags,
// commits A to the output register, then pulses done. An iteration guard and a
// flag-sanity check abort runs that cannot terminate (err pulses together with done).
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   start                    run request, sampled only in IDLE
//   a_gt_b, a_eq_b, a_lt_b   datapath comparator flags
//   a_sel, b_sel             operand muxes: 1 = external data, 0 = subtractor result
//   a_ld, b_ld, output_en    register load enables for A, B and the output register
//   busy, done, err          run status; done/err are one-cycle pulses
//   iter_count               subtract steps taken in the current or last run

module gcd_controller #(
    parameter int MAX_ITER = 255,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a_gt_b,
    input  logic             a_eq_b,
    input  logic             a_lt_b,
    output logic             a_sel,
    output logic             b_sel,
    output logic             a_ld,
    output logic             b_ld,
    output logic             output_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_SUB_A,
        S_SUB_B,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITER);

    state_t state;
    state_t state_next;
    logic   flags_one_hot;

    assign flags_one_hot = ({a_gt_b, a_eq_b, a_lt_b} == 3'b100) ||
                           ({a_gt_b, a_eq_b, a_lt_b} == 3'b010) ||
                           ({a_gt_b, a_eq_b, a_lt_b} == 3'b001);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_LOAD;
            S_LOAD:  state_next = S_CALC;
            S_CALC: begin
                // A corrupted comparator is treated as fatal before anything else;
                // equality wins over the guard so a run finishing on its last step completes.
                if (!flags_one_hot)                 state_next = S_ERR;
                else if (a_eq_b)                    state_next = S_WRITE;
                else if (iter_count == ITER_LIMIT)  state_next = S_ERR;
                else if (a_gt_b)                    state_next = S_SUB_A;
                else                                state_next = S_SUB_B;
            end
            S_SUB_A: state_next = S_CALC;
            S_SUB_B: state_next = S_CALC;
            S_WRITE: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each one is a
    // clean flop output that tracks the current state with no input-to-output path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            a_sel      <= 1'b0;
            b_sel      <= 1'b0;
            a_ld       <= 1'b0;
            b_ld       <= 1'b0;
            output_en  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            iter_count <= '0;
        end else begin
            state     <= state_next;
            a_sel     <= (state_next == S_LOAD);
            b_sel     <= (state_next == S_LOAD);
            a_ld      <= (state_next == S_LOAD) || (state_next == S_SUB_A);
            b_ld      <= (state_next == S_LOAD) || (state_next == S_SUB_B);
            output_en <= (state_next == S_WRITE);
            busy      <= (state_next == S_LOAD)  || (state_next == S_CALC) ||
                         (state_next == S_SUB_A) || (state_next == S_SUB_B) ||
                         (state_next == S_WRITE);
            done      <= (state_next == S_DONE) || (state_next == S_ERR);
            err       <= (state_next == S_ERR);

            // Counter only advances on a subtract step; the CALC guard stops it
            // at ITER_LIMIT, so it cannot wrap. Otherwise it holds for readback.
            if (state == S_IDLE && start)
                iter_count <= '0;
            else if (state == S_SUB_A || state == S_SUB_B)
                iter_count <= iter_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_gcd_controller.sv
// tb/tb_gcd_controller.sv - self-checking bench for gcd_controller with a behavioural datapath

module tb_gcd_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       a_gt_b, a_eq_b, a_lt_b;
    logic       a_sel, b_sel, a_ld, b_ld, output_en, busy, done, err;
    logic [7:0] iter_count;

    logic [7:0] din1 = 8'd0;
    logic [7:0] din2 = 8'd0;
    logic [7:0] a_reg = 8'd0;
    logic [7:0] b_reg = 8'd0;
    logic [7:0] out_reg = 8'd0;
    bit         force_bad = 1'b0;

    int checks = 0;
    int errors = 0;
    int viol = 0;
    int oe_cnt = 0;

    always #5 clk = ~clk;

    gcd_controller #(.MAX_ITER(255), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_gt_b     (a_gt_b),
        .a_eq_b     (a_eq_b),
        .a_lt_b     (a_lt_b),
        .a_sel      (a_sel),
        .b_sel      (b_sel),
        .a_ld       (a_ld),
        .b_ld       (b_ld),
        .output_en  (output_en),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .iter_count (iter_count)
    );

    // Datapath stand-in: registers, muxes, subtractors, comparator (overridable).
    assign a_gt_b = force_bad ? 1'b1 : (a_reg > b_reg);
    assign a_eq_b = force_bad ? 1'b0 : (a_reg == b_reg);
    assign a_lt_b = force_bad ? 1'b1 : (a_reg < b_reg);

    always @(posedge clk) begin
        if (a_ld)      a_reg   <= a_sel ? din1 : a_reg - b_reg;
        if (b_ld)      b_reg   <= b_sel ? din2 : b_reg - a_reg;
        if (output_en) out_reg <= a_reg;
    end

    always @(negedge clk) begin
        if (output_en) oe_cnt <= oe_cnt + 1;
        if (!rst) begin
            if ((a_sel || b_sel) && !(a_ld && b_ld))  viol <= viol + 1;
            if ((a_ld && b_ld) && !(a_sel && b_sel))  viol <= viol + 1;
            if (output_en && (a_ld || b_ld))          viol <= viol + 1;
            if (err && !done)                         viol <= viol + 1;
            if (done && busy)                         viol <= viol + 1;
        end
    end

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Reference: repeated subtraction of the smaller from the larger; a zero
    // operand against a nonzero one never progresses and hits the 255-step guard.
    function automatic void ref_gcd(input int a, input int b, output int g,
                                    output int steps, output bit e, output int lat);
        int x, y;
        x = a; y = b; steps = 0; e = 0; g = 0;
        if (x != y && (x == 0 || y == 0)) begin
            e = 1; steps = 255;
        end else begin
            while (x != y) begin
                if (x > y) x = x - y; else y = y - x;
                steps++;
            end
            g = x;
        end
        lat = e ? (2 * 255 + 3) : (2 * steps + 4);
    endfunction

    // Cycle 1 is the LOAD cycle right after the edge that samples start;
    // lat is the cycle in which done is first seen (-1 on timeout).
    task automatic run(input logic [7:0] a, input logic [7:0] b, output int lat,
                       output int it, output bit e, output int o, output int oe);
        int oe0;
        @(negedge clk);
        din1 = a; din2 = b; start = 1'b1;
        oe0 = oe_cnt;
        lat = -1; it = 0; e = 0; o = 0;
        for (int k = 1; k <= 1100; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = k; it = int'(iter_count); e = err; o = int'(out_reg);
                break;
            end
        end
        #1;
        oe = oe_cnt - oe0;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         out;
        int         iter;
        bit         e;
        int         lat;
        bit         keep;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int lat, it, o, oe, g, st, rl, out0, done_at, dcnt, busy9;
        bit e, re;
        string tag;

        tbl[0] = '{8'd12,  8'd8,   4,  2,   1'b0, 8,   1'b0};
        tbl[1] = '{8'd37,  8'd37,  37, 0,   1'b0, 4,   1'b0};
        tbl[2] = '{8'd255, 8'd1,   1,  254, 1'b0, 512, 1'b0};
        tbl[3] = '{8'd0,   8'd5,   0,  255, 1'b1, 513, 1'b1};
        tbl[4] = '{8'd0,   8'd0,   0,  0,   1'b0, 4,   1'b0};
        tbl[5] = '{8'd9,   8'd6,   3,  2,   1'b0, 8,   1'b0};
        tbl[6] = '{8'd1,   8'd255, 1,  254, 1'b0, 512, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", int'({a_sel, b_sel, a_ld, b_ld, output_en, busy, done, err}), 0);
        chk("reset_iter", int'(iter_count), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // Table-driven runs
        foreach (tbl[i]) begin
            out0 = int'(out_reg);
            run(tbl[i].a, tbl[i].b, lat, it, e, o, oe);
            tag = $sformatf("tbl%0d(%0d,%0d)", i, tbl[i].a, tbl[i].b);
            chk({tag, "_lat"}, lat, tbl[i].lat);
            chk({tag, "_iter"}, it, tbl[i].iter);
            chk({tag, "_err"}, int'(e), int'(tbl[i].e));
            chk({tag, "_out"}, o, tbl[i].keep ? out0 : tbl[i].out);
            chk({tag, "_oe_cycles"}, oe, tbl[i].keep ? 0 : 1);
            @(negedge clk);
            chk({tag, "_done_pulse"}, int'({done, err, busy}), 0);
            chk({tag, "_iter_hold"}, int'(iter_count), tbl[i].iter);
        end

        // Randomized runs against the reference
        for (int i = 0; i < 24; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (i == 5)  ra = 8'd0;
            if (i == 11) rb = 8'd0;
            if (i == 17) rb = ra;
            ref_gcd(int'(ra), int'(rb), g, st, re, rl);
            out0 = int'(out_reg);
            run(ra, rb, lat, it, e, o, oe);
            tag = $sformatf("rnd%0d(%0d,%0d)", i, ra, rb);
            chk({tag, "_lat"}, lat, rl);
            chk({tag, "_iter"}, it, st);
            chk({tag, "_err"}, int'(e), int'(re));
            chk({tag, "_out"}, o, re ? out0 : g);
        end

        // Start pulses during SUB_A (cycle 3) and DONE (cycle 8) are ignored
        @(negedge clk);
        din1 = 8'd12; din2 = 8'd8; start = 1'b1;
        done_at = -1; dcnt = 0; busy9 = 0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                if (done_at < 0) done_at = k;
                dcnt++;
            end
            if (k >= 9 && busy) busy9++;
            start = (k == 3 || k == 8);
        end
        start = 1'b0;
        chk("ignore_start_done_at", done_at, 8);
        chk("ignore_start_done_cnt", dcnt, 1);
        chk("ignore_start_no_rerun", busy9, 0);
        chk("ignore_start_out", int'(out_reg), 4);

        // Held start: back-to-back runs with one IDLE cycle between
        @(negedge clk);
        din1 = 8'd37; din2 = 8'd37; start = 1'b1;
        done_at = -1; dcnt = 0; busy9 = 0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                if (done_at < 0) done_at = k;
                dcnt++;
            end
            if (k == 5) busy9 = int'(busy);
            if (k == 6) busy9 = busy9 + 2 * int'(busy);
        end
        start = 1'b0;
        chk("held_start_first_done", done_at, 4);
        chk("held_start_done_cnt", dcnt, 2);
        chk("held_start_idle_gap", busy9, 2);
        @(negedge clk);

        // Reset in SUB_B (cycle 5) discards the run
        @(negedge clk);
        din1 = 8'd12; din2 = 8'd8; start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_reset_b_ld", int'(b_ld), 1);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", int'({a_sel, b_sel, a_ld, b_ld, output_en, busy, done, err}), 0);
        chk("async_reset_iter", int'(iter_count), 0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("after_reset_quiet", dcnt, 0);
        run(8'd9, 8'd6, lat, it, e, o, oe);
        chk("after_reset_out", o, 3);
        chk("after_reset_lat", lat, 8);

        // Non-one-hot comparator flags abort from CALC
        force_bad = 1'b1;
        out0 = int'(out_reg);
        run(8'd12, 8'd8, lat, it, e, o, oe);
        chk("bad_flags_lat", lat, 3);
        chk("bad_flags_err", int'(e), 1);
        chk("bad_flags_out", o, out0);
        chk("bad_flags_no_oe", oe, 0);
        @(negedge clk);
        chk("bad_flags_idle", int'({done, err, busy}), 0);
        force_bad = 1'b0;

        repeat (2) @(negedge clk);
        chk("strobe_invariants", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
